control_fsm: RTL

CONTROL_FSM -- requirements
Module: control_fsm

---
 rtl/control_fsm_if.sv | 33 +++
 rtl/control_fsm.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/control_fsm_if.sv
// Control bundle between the multi-cycle sequencer and its datapath.
// The sequencer takes the master side; the datapath (or a bench) takes the slave side.
interface control_fsm_if;
  logic        run;
  logic [3:0]  opcode;
  logic        alu_zero;
  logic        alu_neg;
  logic        ir_load_hi;
  logic        ir_load_lo;
  logic        pc_inc;
  logic        pc_load;
  logic        jump_sel;
  logic        alu_en;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        wb_sel;
  logic        halted;
  logic [2:0]  state;
  logic [15:0] instr_count;

  modport master (
    input  run, opcode, alu_zero, alu_neg,
    output ir_load_hi, ir_load_lo, pc_inc, pc_load, jump_sel, alu_en,
           mem_read, mem_write, reg_write, wb_sel, halted, state, instr_count
  );

  modport slave (
    output run, opcode, alu_zero, alu_neg,
    input  ir_load_hi, ir_load_lo, pc_inc, pc_load, jump_sel, alu_en,
           mem_read, mem_write, reg_write, wb_sel, halted, state, instr_count
  );
endinterface

// File: rtl/control_fsm.sv
// Multi-cycle instruction sequencer: two-byte fetch, decode, execute,
// optional memory wait of MEM_LAT cycles, write-back, and a sticky HALT.
module control_fsm #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  control_fsm_if.master bus
);

  typedef enum logic [2:0] {
    FETCH_HI  = 3'd0,
    FETCH_LO  = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    MEMORY    = 3'd4,
    WRITEBACK = 3'd5,
    HALT      = 3'd6
  } state_e;

  localparam logic [3:0] OP_LW  = 4'h2;
  localparam logic [3:0] OP_BEQ = 4'h5;
  localparam logic [3:0] OP_BNE = 4'h6;
  localparam logic [3:0] OP_JMP = 4'h9;
  localparam logic [3:0] OP_SW  = 4'hA;
  localparam logic [3:0] OP_HLT = 4'hD;
  localparam logic [3:0] OP_BLT = 4'hF;
  localparam logic [3:0] WAIT_INIT = 4'(MEM_LAT - 1);

  state_e      state_q, state_d;
  logic [3:0]  opcode_q, opcode_d;
  logic [3:0]  wait_q, wait_d;
  logic [15:0] count_q, count_d;
  logic        retire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FETCH_HI;
      opcode_q <= 4'h0;
      wait_q   <= 4'h0;
      count_q  <= 16'h0000;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      wait_q   <= wait_d;
      count_q  <= count_d;
    end
  end

  // Strobes are gated by rst_n so nothing fires while reset holds FETCH_HI with run=1.
  always_comb begin
    state_d        = state_q;
    opcode_d       = opcode_q;
    wait_d         = wait_q;
    retire         = 1'b0;
    bus.ir_load_hi = 1'b0;
    bus.ir_load_lo = 1'b0;
    bus.pc_inc     = 1'b0;
    bus.pc_load    = 1'b0;
    bus.jump_sel   = 1'b0;
    bus.alu_en     = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.reg_write  = 1'b0;
    bus.wb_sel     = 1'b0;
    bus.halted     = 1'b0;
    if (rst_n) begin
      case (state_q)
        FETCH_HI: begin
          if (bus.run) begin
            bus.ir_load_hi = 1'b1;
            bus.pc_inc     = 1'b1;
            state_d        = FETCH_LO;
          end
        end
        FETCH_LO: begin
          bus.ir_load_lo = 1'b1;
          bus.pc_inc     = 1'b1;
          state_d        = DECODE;
        end
        DECODE: begin
          opcode_d = bus.opcode;
          if (bus.opcode == OP_HLT) begin
            state_d = HALT;
            retire  = 1'b1;
          end else begin
            state_d = EXECUTE;
          end
        end
        EXECUTE: begin
          bus.alu_en = (opcode_q != OP_JMP);
          case (opcode_q)
            OP_LW, OP_SW: begin
              state_d = MEMORY;
              wait_d  = WAIT_INIT;
            end
            OP_BEQ: begin
              bus.pc_load = bus.alu_zero;
              state_d     = FETCH_HI;
              retire      = 1'b1;
            end
            OP_BNE: begin
              bus.pc_load = ~bus.alu_zero;
              state_d     = FETCH_HI;
              retire      = 1'b1;
            end
            OP_BLT: begin
              bus.pc_load = bus.alu_neg;
              state_d     = FETCH_HI;
              retire      = 1'b1;
            end
            OP_JMP: begin
              bus.pc_load  = 1'b1;
              bus.jump_sel = 1'b1;
              state_d      = FETCH_HI;
              retire       = 1'b1;
            end
            default: state_d = WRITEBACK;
          endcase
        end
        MEMORY: begin
          bus.mem_read  = (opcode_q == OP_LW);
          bus.mem_write = (opcode_q != OP_LW);
          if (wait_q == 4'h0) begin
            if (opcode_q == OP_LW) begin
              state_d = WRITEBACK;
            end else begin
              state_d = FETCH_HI;
              retire  = 1'b1;
            end
          end else begin
            wait_d = wait_q - 4'h1;
          end
        end
        WRITEBACK: begin
          bus.reg_write = 1'b1;
          bus.wb_sel    = (opcode_q == OP_LW);
          state_d       = FETCH_HI;
          retire        = 1'b1;
        end
        HALT: begin
          bus.halted = 1'b1;
        end
        default: state_d = FETCH_HI;
      endcase
    end
  end

  always_comb begin
    count_d = count_q;
    if (retire && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'h0001;
    end
  end

  assign bus.state       = state_q;
  assign bus.instr_count = count_q;

endmodule
